// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter in front of a single-port 2^ADDR_SIZE x REG_SIZE data RAM.
// Serves one core access per cycle and acknowledges each grant with a one-cycle val pulse.
module core_mem_arbiter #(
  parameter int unsigned CORES_NUM = 4,
  parameter int unsigned ADDR_SIZE = 12,
  parameter int unsigned REG_SIZE  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*CORES_NUM-1:0]        enable,
  input  logic [ADDR_SIZE*CORES_NUM-1:0] addr,
  input  logic [REG_SIZE*CORES_NUM-1:0]  wr_data,
  output logic [REG_SIZE*CORES_NUM-1:0]  rd_data,
  output logic [CORES_NUM-1:0]           val
);

  localparam int unsigned PTR_W  = (CORES_NUM > 1) ? $clog2(CORES_NUM) : 1;
  localparam int unsigned DEPTH  = 1 << ADDR_SIZE;
  localparam logic [1:0]  REQ_RD = 2'b01;
  localparam logic [1:0]  REQ_WR = 2'b10;

  logic [REG_SIZE-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic [CORES_NUM-1:0] grant_mask;
  logic [CORES_NUM-1:0] eligible;
  logic [CORES_NUM-1:0] grant_oh;
  logic                 grant_vld;
  logic                 grant_wr;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [REG_SIZE-1:0]  sel_wdata;
  int unsigned          cand;

  // A core may compete when it issues a read/write and was not served last cycle.
  always_comb begin : eligibility
    eligible = '0;
    for (int unsigned i = 0; i < CORES_NUM; i++) begin
      eligible[i] = ~reset & ~grant_mask[i] &
                    ((enable[2*i +: 2] == REQ_RD) | (enable[2*i +: 2] == REQ_WR));
    end
  end

  // First eligible core scanning upward from rr_ptr with wrap-around.
  always_comb begin : arbitration
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = 0;
    for (int unsigned k = 0; k < CORES_NUM; k++) begin
      cand = (32'(rr_ptr) + k) % CORES_NUM;
      if (!grant_vld && eligible[PTR_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(cand);
      end
    end
    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // Route the winner's address, data and direction to the RAM port.
  always_comb begin : grant_mux
    sel_addr  = '0;
    sel_wdata = '0;
    grant_wr  = 1'b0;
    for (int unsigned i = 0; i < CORES_NUM; i++) begin
      if (grant_oh[i]) begin
        sel_addr  = addr[i*ADDR_SIZE +: ADDR_SIZE];
        sel_wdata = wr_data[i*REG_SIZE +: REG_SIZE];
        grant_wr  = (enable[2*i +: 2] == REQ_WR);
      end
    end
  end

  always_ff @(posedge clk) begin : arb_state
    if (reset) begin
      rr_ptr     <= '0;
      grant_mask <= '0;
    end else begin
      grant_mask <= grant_oh;
      if (grant_vld) begin
        rr_ptr <= (grant_idx == PTR_W'(CORES_NUM - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin : read_port
    if (reset) begin
      rd_data <= '0;
    end else if (grant_vld && !grant_wr) begin
      for (int unsigned i = 0; i < CORES_NUM; i++) begin
        if (grant_oh[i]) begin
          rd_data[i*REG_SIZE +: REG_SIZE] <= mem[sel_addr];
        end
      end
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin : write_port
    if (grant_vld && grant_wr) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  // An ack whose cycle coincides with reset is dropped rather than delivered.
  assign val = grant_mask & {CORES_NUM{~reset}};

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomized and directed checks of core_mem_arbiter against a queue-free behavioural model.
module tb_core_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [2*N-1:0]  enable;
  logic [AW*N-1:0] addr;
  logic [DW*N-1:0] wr_data;
  logic [DW*N-1:0] rd_data;
  logic [N-1:0]    val;

  int passed = 0;
  int total  = 0;

  // Per-core request registers (what each core is presenting).
  logic [1:0]    q_en   [N];
  logic [AW-1:0] q_addr [N];
  logic [DW-1:0] q_wd   [N];

  // Reference model state.
  logic [DW-1:0] m_mem [logic [AW-1:0]];
  logic [DW-1:0] m_rd  [N];
  logic [N-1:0]  m_val;
  int            m_ptr;

  logic [AW-1:0] pool [8] = '{12'h123, 12'h7FF, 12'h000, 12'hFFF,
                              12'h0A5, 12'h400, 12'h3C3, 12'h801};

  core_mem_arbiter #(.CORES_NUM(N), .ADDR_SIZE(AW), .REG_SIZE(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .val(val)
  );

  always #5 clk = ~clk;

  function automatic logic [DW*N-1:0] exp_rd();
    logic [DW*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = m_rd[i];
    return r;
  endfunction

  // One arbitration cycle: first requesting, not-just-served core from the pointer wins.
  task automatic model_step();
    int g;
    if (reset) begin
      m_ptr = 0;
      m_val = '0;
      for (int i = 0; i < N; i++) m_rd[i] = '0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && (q_en[c] == 2'b01 || q_en[c] == 2'b10) && !m_val[c]) g = c;
      end
      m_val = '0;
      if (g >= 0) begin
        m_val[g] = 1'b1;
        if (q_en[g] == 2'b10) m_mem[q_addr[g]] = q_wd[g];
        else m_rd[g] = m_mem.exists(q_addr[g]) ? m_mem[q_addr[g]] : 8'h00;
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      enable[2*i +: 2]   = q_en[i];
      addr[i*AW +: AW]   = q_addr[i];
      wr_data[i*DW +: DW] = q_wd[i];
    end
  endtask

  task automatic tick();
    drive();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_idle();
    for (int i = 0; i < N; i++) begin
      q_en[i] = 2'b00; q_addr[i] = '0; q_wd[i] = '0;
    end
  endtask

  task automatic test_reset();
    all_idle();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (val !== 4'b0000) $display("FAIL reset_val: got %b expected 0000", val);
    else passed++;
    total++;
    if (rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h expected 00000000", rd_data);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    q_en[0] = 2'b10; q_addr[0] = 12'h123; q_wd[0] = 8'h5A;
    tick();
    total++;
    if (val !== 4'b0001) $display("FAIL wr_ack: got %b expected 0001", val);
    else passed++;
    total++;
    if (rd_data[7:0] !== 8'h00) $display("FAIL wr_keeps_rd: got %h expected 00", rd_data[7:0]);
    else passed++;
    q_en[0] = 2'b01;
    tick();
    total++;
    if (val !== 4'b0000) $display("FAIL masked_cycle: got %b expected 0000", val);
    else passed++;
    tick();
    total++;
    if (val !== 4'b0001) $display("FAIL rd_ack: got %b expected 0001", val);
    else passed++;
    total++;
    if (rd_data[7:0] !== 8'h5A) $display("FAIL rd_value: got %h expected 5a", rd_data[7:0]);
    else passed++;
    q_en[0] = 2'b00;
    tick();
    total++;
    if (rd_data[7:0] !== 8'h5A || val !== 4'b0000)
      $display("FAIL rd_hold: got %h/%b expected 5a/0000", rd_data[7:0], val);
    else passed++;
  endtask

  task automatic test_preload();
    for (int j = 0; j < 8; j++) begin
      int c;
      bit done;
      c = j % N;
      q_en[c] = 2'b10; q_addr[c] = pool[j]; q_wd[c] = DW'($urandom);
      done = 1'b0;
      for (int t = 0; t < 8 && !done; t++) begin
        tick();
        total++;
        if (val !== m_val) $display("FAIL preload_val: got %b expected %b", val, m_val);
        else passed++;
        done = m_val[c];
      end
      total++;
      if (!done) $display("FAIL preload_timeout: core %0d got no ack expected ack", c);
      else passed++;
      q_en[c] = 2'b00;
    end
    tick();
  endtask

  task automatic test_all_read();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      q_en[i] = 2'b01; q_addr[i] = pool[i];
    end
    for (int k = 0; k < N; k++) begin
      logic [N-1:0] want;
      want = N'(1) << k;
      tick();
      total++;
      if (val !== want) $display("FAIL all_read_order: cycle %0d got %b expected %b", k + 1, val, want);
      else passed++;
      total++;
      if (rd_data[k*DW +: DW] !== m_mem[pool[k]])
        $display("FAIL all_read_data: core %0d got %h expected %h", k, rd_data[k*DW +: DW], m_mem[pool[k]]);
      else passed++;
    end
    all_idle();
    tick();
  endtask

  task automatic test_hazard();
    q_en[1] = 2'b01; q_addr[1] = 12'h123;
    tick();
    total++;
    if (val !== 4'b0010) $display("FAIL hazard_setup: got %b expected 0010", val);
    else passed++;
    q_en[1] = 2'b00;
    tick();
    q_en[2] = 2'b10; q_addr[2] = 12'h7FF; q_wd[2] = 8'hC3;
    q_en[1] = 2'b01; q_addr[1] = 12'h7FF;
    tick();
    total++;
    if (val !== 4'b0100) $display("FAIL hazard_write_first: got %b expected 0100", val);
    else passed++;
    q_en[2] = 2'b00;
    tick();
    total++;
    if (val !== 4'b0010) $display("FAIL hazard_read_next: got %b expected 0010", val);
    else passed++;
    total++;
    if (rd_data[15:8] !== 8'hC3) $display("FAIL hazard_data: got %h expected c3", rd_data[15:8]);
    else passed++;
    all_idle();
    tick();
  endtask

  task automatic test_single_stream();
    logic prev3;
    q_en[0] = 2'b11; q_addr[0] = pool[5];
    q_en[3] = 2'b01; q_addr[3] = pool[3];
    prev3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (val[3] !== ((k % 2) == 0) || val[0] !== 1'b0 || (val[3] && prev3))
        $display("FAIL single_stream: cycle %0d got %b expected %b", k, val, ((k % 2) == 0) ? 4'b1000 : 4'b0000);
      else passed++;
      prev3 = val[3];
    end
    all_idle();
    tick();
  endtask

  task automatic test_reset_pending();
    q_en[1] = 2'b01; q_addr[1] = pool[0];
    tick();
    q_en[1] = 2'b00;
    reset = 1'b1;
    #1;
    total++;
    if (val[1] !== 1'b0) $display("FAIL dropped_ack: got %b expected 0", val[1]);
    else passed++;
    tick();
    total++;
    if (rd_data !== 32'h0 || val !== 4'b0000)
      $display("FAIL reset_clear: got %h/%b expected 00000000/0000", rd_data, val);
    else passed++;
    reset = 1'b0;
    q_en[0] = 2'b01; q_addr[0] = pool[1];
    q_en[1] = 2'b01; q_addr[1] = pool[2];
    tick();
    total++;
    if (val !== 4'b0001) $display("FAIL post_reset_first: got %b expected 0001", val);
    else passed++;
    q_en[0] = 2'b00;
    tick();
    total++;
    if (val !== 4'b0010) $display("FAIL post_reset_second: got %b expected 0010", val);
    else passed++;
    total++;
    if (rd_data !== exp_rd()) $display("FAIL post_reset_data: got %h expected %h", rd_data, exp_rd());
    else passed++;
    all_idle();
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      total++;
      if (val !== m_val || rd_data !== exp_rd())
        $display("FAIL random: cycle %0d got %b/%h expected %b/%h", cyc, val, rd_data, m_val, exp_rd());
      else passed++;
      // Served cores and non-requesting cores may present something new; pending ones hold.
      for (int i = 0; i < N; i++) begin
        if (m_val[i] || q_en[i] == 2'b00 || q_en[i] == 2'b11) begin
          q_en[i]   = 2'($urandom_range(0, 3));
          q_addr[i] = pool[$urandom_range(0, 7)];
          q_wd[i]   = DW'($urandom);
        end
      end
    end
    all_idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    m_val = '0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_rd[i] = '0;
    all_idle();
    drive();
    test_reset();
    test_write_read();
    test_preload();
    test_all_read();
    test_hazard();
    test_single_stream();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shared data-memory block sitting directly downstream of the compute cores' memory ports (`enable`/`addr`/`wr_data` out, `rd_data`/`val` in). It owns a single-port 4096×8 RAM and arbitrates among `CORES_NUM` cores round-robin, serving at most one access per cycle. Each accepted access is acknowledged by a one-cycle `val` pulse to the requesting core.

## Interface
- `CORES_NUM`, 4: number of attached cores (≥1).
- `ADDR_SIZE`, 12: address width; memory depth is 2^ADDR_SIZE.
- `REG_SIZE`, 8: data word width.

- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `enable` in 2·CORES_NUM: per-core request, slice i = bits [2i+1:2i]; 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 reserved (treated as idle).
- `addr` in ADDR_SIZE·CORES_NUM: per-core address, slice i = [(i+1)·ADDR_SIZE-1 : i·ADDR_SIZE].
- `wr_data` in REG_SIZE·CORES_NUM: per-core write data, same slicing.
- `rd_data` out REG_SIZE·CORES_NUM: per-core read result, registered.
- `val` out CORES_NUM: per-core completion pulse.

## Operation
- Core i is eligible in cycle T when its enable is 01 or 10 and it was not granted in T-1 (`val[i]` is high in T, and the core's request is still visible).
- Winner: first eligible core scanning upward from `rr_ptr`, wrapping CORES_NUM-1 → 0. On grant to core g, `rr_ptr` ← (g+1) mod CORES_NUM. No eligible core: `rr_ptr` unchanged, RAM untouched.
- Write grant: `mem[addr_g]` ← `wr_data_g` at end of T.
- Read grant: RAM read at end of T; `rd_data` slice g updated with `mem[addr_g]` at end of T.
- `rd_data` slice i holds its value until core i's next read completes; writes never change it.
- Accesses are fully serialized in grant order: a read granted after a write to the same address returns the written value.
- Reserved encoding 11: never granted, never produces `val`.
- Cores hold `enable`/`addr`/`wr_data` stable until they see `val`; the arbiter samples them only in the grant cycle.
- RAM contents are not cleared by reset.

## Timing
- Latency: grant in cycle T → `val[g]` = 1 in T+1 for exactly one cycle; read data valid on `rd_data` slice g in T+1 (and onward).
- Throughput: one access per cycle across all cores; a single core with continuous requests is served every other cycle (grant, masked, grant…).
- Simultaneous requests from all cores: each served once per CORES_NUM grants; no starvation.
- Reset values: `val` = 0, all `rd_data` slices = 0, `rr_ptr` = 0, grant-mask = 0.
- Reset asserted while a grant is pending: `val` forced 0 in the next cycle, the pending ack is dropped; a write already committed in the previous cycle stays in RAM.
- Requests sampled in a cycle where `reset` = 1 are ignored.

## Test plan
- Core 0 writes 0x5A to 0x123 (enable 10), then reads 0x123 (enable 01) → `val[0]` pulses one cycle after each grant; `rd_data[7:0]` = 0x5A after the read ack, unchanged after the write ack.
- After reset all four cores request reads simultaneously and hold → grants in order 0,1,2,3 on consecutive cycles; `val` = 0001, 0010, 0100, 1000 in cycles 1–4 after the request.
- Core 2 writes 0xC3 to 0x7FF in cycle T, core 1 reads 0x7FF requested in T (not yet granted) → core 1 granted in T+1 (rr_ptr = 3 wraps to 1) and `rd_data` slice 1 = 0xC3.
- Core 3 alone requests continuously (reads) → `val[3]` high every second cycle, never two consecutive cycles; enable = 11 on core 0 throughout → `val[0]` never asserts.
- Assert `reset` one cycle after granting a core-1 read → no `val[1]` pulse; all `rd_data` = 0; next simultaneous cores 1 and 0 requests → core 0 granted first.
